// File: rtl/lsu_mmio.sv
// lsu_mmio: load-store unit for data memory and memory-mapped I/O; one request per two cycles.
// Define LSU_MISALIGN_EN to fault misaligned/illegal accesses instead of aligning them down.
module lsu_mmio #(
  parameter int DMEM_AW = 11,
  parameter int N_OUT   = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          st_data_i,
  input  logic [31:0]          sw_i,
  output logic                 rsp_valid_o,
  output logic [31:0]          ld_data_o,
  output logic                 err_o,
  output logic [32*N_OUT-1:0]  io_out_o
);
  typedef enum logic {IDLE, RESP} state_e;
  state_e state_q, state_d;
  logic [31:0] mem [2**(DMEM_AW-2)];
  logic [31:0] out_q [N_OUT];
  logic [31:0] mem_rd_q, cap_q, cap_d, sw1_q, sw2_q, wdata, sh;
  logic [11:0] a;
  logic [3:0]  oidx, be;
  logic [1:0]  lane, lane_q, size_q;
  logic        acc, mis, is_dmem, is_out, is_sw, st_ok;
  logic        ld_q, dmem_q, err_q, uns_q;
  logic        unused_addr;
  assign unused_addr = ^addr_i[31:12];
  assign a       = addr_i[11:0];
  assign oidx    = a[7:4];
  assign acc     = req_valid_i && state_q == IDLE;
`ifdef LSU_MISALIGN_EN
  assign mis = (req_size_i == 2'b01 && a[0]) || (req_size_i == 2'b10 && a[1:0] != 2'b00) ||
               req_size_i == 2'b11;
`else
  assign mis = 1'b0;
`endif
  assign is_dmem = a[11:10] == 2'b00;
  assign is_out  = a[11:8] == 4'h4 && a[3:2] == 2'b00 && int'(oidx) < N_OUT;
  assign is_sw   = a[11:2] == 10'h140;
  // Aligning the lane down is what makes size 11 behave as a word when faults are disabled.
  assign lane  = req_size_i == 2'b00 ? a[1:0] : req_size_i == 2'b01 ? {a[1], 1'b0} : 2'b00;
  assign be    = req_size_i == 2'b00 ? 4'b0001 << lane : req_size_i == 2'b01 ?
                 (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = req_size_i == 2'b00 ? {4{st_data_i[7:0]}} :
                 req_size_i == 2'b01 ? {2{st_data_i[15:0]}} : st_data_i;
  assign st_ok = acc && req_we_i && !mis;
  always_comb begin
    cap_d = '0;
    for (int i = 0; i < N_OUT; i++) cap_d = (is_out && oidx == 4'(i)) ? out_q[i] : cap_d;
    cap_d = is_sw ? sw2_q : cap_d;
  end
  always_ff @(posedge clk_i) begin
    if (acc && is_dmem && !mis) begin
      for (int b = 0; b < 4; b++)
        if (req_we_i && be[b]) mem[addr_i[DMEM_AW-1:2]][8*b +: 8] <= wdata[8*b +: 8];
      mem_rd_q <= mem[addr_i[DMEM_AW-1:2]];
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sw1_q   <= '0;
      sw2_q   <= '0;
      cap_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      ld_q    <= 1'b0;
      dmem_q  <= 1'b0;
      err_q   <= 1'b0;
      uns_q   <= 1'b0;
      for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sw1_q   <= sw_i;
      sw2_q   <= sw1_q;
      if (acc) begin
        cap_q  <= cap_d;
        lane_q <= lane;
        size_q <= req_size_i;
        ld_q   <= !req_we_i && !mis;
        dmem_q <= is_dmem;
        err_q  <= mis;
        uns_q  <= req_unsigned_i;
      end
      for (int i = 0; i < N_OUT; i++)
        for (int b = 0; b < 4; b++)
          if (st_ok && is_out && oidx == 4'(i) && be[b]) out_q[i][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
  always_comb state_d = (state_q == IDLE && req_valid_i) ? RESP : IDLE;
  assign sh          = (dmem_q ? mem_rd_q : cap_q) >> {lane_q, 3'b000};
  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign err_o       = rsp_valid_o && err_q;
  assign ld_data_o   = !(rsp_valid_o && ld_q) ? 32'h0 :
                       size_q == 2'b00 ? {{24{!uns_q && sh[7]}}, sh[7:0]} :
                       size_q == 2'b01 ? {{16{!uns_q && sh[15]}}, sh[15:0]} : sh;
  for (genvar g = 0; g < N_OUT; g++) begin : g_io
    assign io_out_o[32*g +: 32] = out_q[g];
  end
endmodule

// File: tb/tb_lsu_mmio.sv
// tb_lsu_mmio: directed test of lsu_mmio against a byte-level behavioural model.
module tb_lsu_mmio;
  localparam int AW = 11, NO = 12;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] addr = '0, st_data = '0, sw = '0;
  logic ready, rsp, err;
  logic [31:0] ld;
  logic [32*NO-1:0] io;
  int passed = 0, total = 0;

  lsu_mmio #(.DMEM_AW(AW), .N_OUT(NO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns), .addr_i(addr),
    .st_data_i(st_data), .sw_i(sw), .rsp_valid_o(rsp), .ld_data_o(ld), .err_o(err),
    .io_out_o(io));

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", n, act, exp);
  endtask

  // Model: memory as bytes, output registers, and the switch value seen two edges late.
  logic [7:0]  dm [1024];
  logic [31:0] om [NO];
  logic [31:0] sw1 = '0, sw2 = '0, e_ld = '0;
  logic        e_rsp = 1'b0, e_err = 1'b0;

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic misal(input logic [1:0] s, input logic [11:0] a);
`ifdef LSU_MISALIGN_EN
    return (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0) || s == 2'd3;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [11:0] eff(input logic [1:0] s, input logic [11:0] a);
    return a - a % 12'(nbytes(s));
  endfunction
  function automatic int region(input logic [11:0] ea);
    if (ea < 12'h400) return 0;
    if (ea >= 12'h400 && ea < 12'h400 + 12'(16 * NO) && ea % 16 < 4) return 1;
    if (ea >= 12'h500 && ea < 12'h504) return 2;
    return 3;
  endfunction
  function automatic logic [31:0] mword(input logic [11:0] ea);
    int b;
    b = int'(ea) / 4 * 4;
    case (region(ea))
      0: return {dm[b+3], dm[b+2], dm[b+1], dm[b]};
      1: return om[(int'(ea) - 'h400) / 16];
      2: return sw2;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] mload(input logic [1:0] s, input logic u, input logic [11:0] a);
    logic [11:0] ea;
    logic [31:0] v, m;
    int n;
    if (misal(s, a)) return 32'h0;
    ea = eff(s, a);
    n  = nbytes(s);
    v  = mword(ea) >> (8 * (int'(ea) % 4));
    m  = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    v  = v & m;
    if (!u && n < 4 && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rsp <= 1'b0; e_ld <= '0; e_err <= 1'b0; sw1 <= '0; sw2 <= '0;
      for (int i = 0; i < NO; i++) om[i] <= '0;
    end else begin
      sw1 <= sw;
      sw2 <= sw1;
      if (req_valid && !e_rsp) begin
        e_rsp <= 1'b1;
        e_err <= misal(req_size, addr[11:0]);
        e_ld  <= req_we ? 32'h0 : mload(req_size, req_uns, addr[11:0]);
        if (req_we && !misal(req_size, addr[11:0]))
          for (int k = 0; k < nbytes(req_size); k++) begin
            if (region(eff(req_size, addr[11:0])) == 0)
              dm[int'(eff(req_size, addr[11:0])) + k] <= st_data[8*k +: 8];
            else if (region(eff(req_size, addr[11:0])) == 1)
              om[(int'(eff(req_size, addr[11:0])) - 'h400) / 16]
                [8 * (int'(eff(req_size, addr[11:0])) % 4 + k) +: 8] <= st_data[8*k +: 8];
          end
      end else begin
        e_rsp <= 1'b0; e_ld <= '0; e_err <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("ready", 32'(ready), 32'(!e_rsp));
    check("rsp_valid", 32'(rsp), 32'(e_rsp));
    check("ld_data", ld, e_ld);
    check("err", 32'(err), 32'(e_err));
    for (int i = 0; i < NO; i++) check($sformatf("io_out[%0d]", i), io[32*i +: 32], om[i]);
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic u, input logic [11:0] a,
                        input logic [31:0] d, output logic [31:0] g, output logic e);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    req_we = we; req_size = sz; req_uns = u; addr = {20'hABCDE, a}; st_data = d; req_valid = 1'b1;
    while (n < 10) begin
      acc = ready;
      @(posedge clk);
      n++;
      if (acc) break;
      @(negedge clk);
    end
    if (!acc) begin
      total++;
      $display("FAIL accept_timeout: ready stayed %b, required 1", ready);
    end
    @(negedge clk);
    g = ld; e = err; req_valid = 1'b0;
  endtask

  logic [31:0] g;
  logic e;
  int pulses;
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_ready", 32'(ready), 32'd1);
    do_req(1, 2'd2, 0, 12'h010, 32'hDEADBEEF, g, e);
    check("st_ld_zero", g, 32'h0);
    do_req(1, 2'd0, 0, 12'h012, 32'h00000055, g, e);
    do_req(0, 2'd2, 0, 12'h010, 32'h0, g, e);
    check("ld_w_010", g, 32'hDE55BEEF);
    do_req(0, 2'd0, 0, 12'h010, 32'h0, g, e);
    check("ld_b_s_010", g, 32'hFFFFFFEF);
    do_req(0, 2'd1, 1, 12'h012, 32'h0, g, e);
    check("ld_h_u_012", g, 32'h0000DE55);
    do_req(0, 2'd1, 0, 12'h012, 32'h0, g, e);
    check("ld_h_s_012", g, 32'hFFFFDE55);
    do_req(0, 2'd0, 1, 12'h013, 32'h0, g, e);
    check("ld_b_u_013", g, 32'h000000DE);
    do_req(1, 2'd1, 0, 12'h432, 32'hFFFF1234, g, e);
    check("io_reg3", io[3*32 +: 32], 32'h12340000);
    do_req(1, 2'd0, 0, 12'h401, 32'h00000077, g, e);
    check("io_reg0", io[31:0], 32'h00007700);
    do_req(0, 2'd1, 0, 12'h432, 32'h0, g, e);
    check("ld_reg3_h", g, 32'h00001234);
    do_req(1, 2'd2, 0, 12'h4B0, 32'hCAFE0011, g, e);
    check("io_reg11", io[11*32 +: 32], 32'hCAFE0011);
    do_req(1, 2'd2, 0, 12'h4C0, 32'h99999999, g, e);
    do_req(0, 2'd2, 0, 12'h4C0, 32'h0, g, e);
    check("ld_4c0", g, 32'h0);
    do_req(1, 2'd2, 0, 12'h600, 32'hFFFFFFFF, g, e);
    do_req(0, 2'd2, 0, 12'h600, 32'h0, g, e);
    check("ld_600", g, 32'h0);
    do_req(1, 2'd2, 0, 12'h500, 32'h11111111, g, e);
    sw = 32'hA5A5A5A5;
    repeat (3) @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0; addr = 32'h500; req_valid = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp) begin
        pulses++;
        check("ld_sw_held", ld, 32'hA5A5A5A5);
      end
    end
    req_valid = 1'b0;
    check("held_pulses", 32'(pulses), 32'd4);
    sw = 32'h12345678;
    do_req(0, 2'd2, 0, 12'h500, 32'h0, g, e);
    check("sw_1edge", g, 32'hA5A5A5A5);
    do_req(0, 2'd2, 0, 12'h500, 32'h0, g, e);
    check("sw_3edge", g, 32'h12345678);
    do_req(1, 2'd2, 0, 12'h010, 32'h11223344, g, e);
    do_req(1, 2'd2, 0, 12'h011, 32'hCAFEF00D, g, e);
`ifdef LSU_MISALIGN_EN
    check("mis_err", 32'(e), 32'd1);
    do_req(0, 2'd2, 0, 12'h010, 32'h0, g, e);
    check("mis_nowrite", g, 32'h11223344);
    do_req(0, 2'd3, 0, 12'h010, 32'h0, g, e);
    check("size3_err", 32'(e), 32'd1);
`else
    check("mis_err", 32'(e), 32'd0);
    do_req(0, 2'd2, 0, 12'h010, 32'h0, g, e);
    check("mis_aligned", g, 32'hCAFEF00D);
    do_req(0, 2'd3, 0, 12'h012, 32'h0, g, e);
    check("size3_word", g, 32'hCAFEF00D);
`endif
    req_we = 1'b0; req_size = 2'd2; addr = 32'h010; req_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_drop", 32'(rsp), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp) pulses++;
    end
    check("no_pulse_after_rst", 32'(pulses), 32'd0);
    check("io_cleared", io[3*32 +: 32], 32'h0);
    do_req(0, 2'd2, 0, 12'h010, 32'h0, g, e);
`ifdef LSU_MISALIGN_EN
    check("dmem_kept", g, 32'h11223344);
`else
    check("dmem_kept", g, 32'hCAFEF00D);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
